// File: rtl/beep_decoder.sv
// rtl/beep_decoder.sv - measures an incoming tone period and decodes it to a scale note
module beep_decoder #(
  parameter logic [17:0] DO      = 18'd190_840,
  parameter logic [17:0] RE      = 18'd170_068,
  parameter logic [17:0] MI      = 18'd151_515,
  parameter logic [17:0] FA      = 18'd143_266,
  parameter logic [17:0] SO      = 18'd127_551,
  parameter logic [17:0] LA      = 18'd113_636,
  parameter logic [17:0] SI      = 18'd101_214,
  parameter logic [17:0] TOL     = 18'd2_000,
  parameter logic [18:0] TIMEOUT = 19'd400_000,
  parameter logic [2:0]  MATCH_N = 3'd2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        beep_in,
  output logic [2:0]  note,
  output logic        note_valid,
  output logic [17:0] period,
  output logic        active
);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        s1;
  logic        s2;
  logic        s3;
  logic        rise;

  logic [18:0] cnt;
  logic [17:0] period_r;
  logic        cap_pend;

  logic        capture;
  logic        timeout_hit;

  logic [2:0]  cand;
  logic [2:0]  cand_prev;
  logic [2:0]  match_cnt;
  logic [2:0]  match_next;

  // Note index 1..7 maps to its nominal period; index 0 has no period.
  function automatic logic [17:0] note_period(input logic [2:0] k);
    case (k)
      3'd1:    return DO;
      3'd2:    return RE;
      3'd3:    return MI;
      3'd4:    return FA;
      3'd5:    return SO;
      3'd6:    return LA;
      3'd7:    return SI;
      default: return 18'd0;
    endcase
  endfunction

  // Both subtractions are done; the one that wraps lands far above TOL,
  // so whichever direction is non-negative decides the match.
  function automatic logic within_tol(input logic [17:0] p, input logic [17:0] ref_p);
    logic [18:0] d_up;
    logic [18:0] d_dn;
    d_up = {1'b0, p} - {1'b0, ref_p};
    d_dn = {1'b0, ref_p} - {1'b0, p};
    return (d_up <= {1'b0, TOL}) || (d_dn <= {1'b0, TOL});
  endfunction

  assign rise   = s2 & ~s3;
  assign period = period_r;
  assign active = (state == TRACK);

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= beep_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Period counter: reloads to 1 on an edge so P-cycle spacing reads P, saturates at all-ones.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= 19'd0;
    end else if (rise) begin
      cnt <= 19'd1;
    end else if (cnt != '1) begin
      cnt <= cnt + 19'd1;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: an edge always beats a timeout landing in the same cycle.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (rise) begin
          capture = 1'b1;
        end else if (cnt >= TIMEOUT) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the measured period, clipped to the 18-bit output range.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_r <= 18'd0;
      cap_pend <= 1'b0;
    end else begin
      cap_pend <= capture;
      if (capture) begin
        period_r <= cnt[18] ? 18'h3FFFF : cnt[17:0];
      end
    end
  end

  // Classify the captured period; scanning downward lets the lowest matching note win.
  always_comb begin
    cand = 3'd0;
    for (int k = 7; k >= 1; k--) begin
      if (within_tol(period_r, note_period(3'(k)))) begin
        cand = 3'(k);
      end
    end
  end

  // Run length of identical classifications, saturating at MATCH_N.
  always_comb begin
    match_next = 3'd1;
    if (cand == cand_prev) begin
      match_next = (match_cnt >= MATCH_N) ? MATCH_N : match_cnt + 3'd1;
    end
  end

  // Debounced note output: changes only after MATCH_N agreeing periods, or on silence timeout.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      note       <= 3'd0;
      note_valid <= 1'b0;
      cand_prev  <= 3'd0;
      match_cnt  <= 3'd0;
    end else begin
      note_valid <= 1'b0;
      if (timeout_hit) begin
        match_cnt <= 3'd0;
        if (note != 3'd0) begin
          note       <= 3'd0;
          note_valid <= 1'b1;
        end
      end else if (cap_pend) begin
        cand_prev <= cand;
        match_cnt <= match_next;
        if ((match_next == MATCH_N) && (cand != note)) begin
          note       <= cand;
          note_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_beep_decoder.sv
// tb/tb_beep_decoder.sv - self-checking bench for beep_decoder
module tb_beep_decoder;

  localparam logic [17:0] P_DO      = 18'd954;
  localparam logic [17:0] P_RE      = 18'd850;
  localparam logic [17:0] P_MI      = 18'd758;
  localparam logic [17:0] P_FA      = 18'd716;
  localparam logic [17:0] P_SO      = 18'd638;
  localparam logic [17:0] P_LA      = 18'd568;
  localparam logic [17:0] P_SI      = 18'd506;
  localparam logic [17:0] P_TOL     = 18'd10;
  localparam logic [18:0] P_TIMEOUT = 19'd2000;
  localparam int          TO        = 2000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        beep_in = 1'b0;
  logic [2:0]  note;
  logic        note_valid;
  logic [17:0] period;
  logic        active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rise = 0;
  int last_pulse = 0;
  int pulse_count = 0;
  logic prev_nv = 1'b0;
  logic [2:0] exp_q[$];

  typedef struct {
    int p;
    int n;
    int exp_note;
    bit pulse;
  } vec_t;
  vec_t vecs[$];

  beep_decoder #(
    .DO(P_DO), .RE(P_RE), .MI(P_MI), .FA(P_FA), .SO(P_SO), .LA(P_LA), .SI(P_SI),
    .TOL(P_TOL), .TIMEOUT(P_TIMEOUT), .MATCH_N(3'd2)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .beep_in(beep_in),
    .note(note),
    .note_valid(note_valid),
    .period(period),
    .active(active)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk) begin
    if (cyc == 95000) begin
      $display("FAIL watchdog: cycle %0d reached, limit 95000", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse monitor: every note_valid pops one expected note from the scoreboard.
  always @(negedge sys_clk) begin
    if (note_valid) begin
      pulse_count++;
      last_pulse = cyc;
      checks++;
      if (prev_nv) begin
        errors++;
        $display("FAIL nv_back_to_back: got 2 consecutive pulses expected 1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL nv_unexpected: got note %0d pulse expected none", note);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (note !== e) begin
          errors++;
          $display("FAIL nv_note: got %0d expected %0d", note, e);
        end
      end
    end
    prev_nv = note_valid;
  end

  // n rising edges, each followed by p cycles (50% duty), driven on negedges.
  task automatic tone(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      beep_in   = 1'b1;
      last_rise = cyc;
      repeat (p / 2) @(negedge sys_clk);
      beep_in = 1'b0;
      repeat (p - p / 2) @(negedge sys_clk);
    end
  endtask

  initial begin
    int pc;
    int rise_ref;
    int w;

    vecs.push_back('{954, 3, 1, 1'b1});
    vecs.push_back('{635, 3, 5, 1'b1});
    vecs.push_back('{800, 3, 0, 1'b1});
    vecs.push_back('{568, 3, 6, 1'b1});
    vecs.push_back('{506, 3, 7, 1'b1});
    vecs.push_back('{716, 3, 4, 1'b1});
    vecs.push_back('{850, 3, 2, 1'b1});
    vecs.push_back('{758, 3, 3, 1'b1});
    vecs.push_back('{964, 3, 1, 1'b1});
    vecs.push_back('{965, 3, 0, 1'b1});
    vecs.push_back('{944, 3, 1, 1'b1});
    vecs.push_back('{954, 3, 1, 1'b0});
    vecs.push_back('{495, 3, 0, 1'b1});

    repeat (3) @(negedge sys_clk);
    check("rst_note", note, 0);
    check("rst_nv", note_valid, 0);
    check("rst_period", period, 0);
    check("rst_active", active, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Table-driven notes, including exact tolerance boundaries.
    foreach (vecs[i]) begin
      if (vecs[i].pulse) exp_q.push_back(3'(vecs[i].exp_note));
      tone(vecs[i].p, vecs[i].n);
      check($sformatf("vec%0d_note", i), note, vecs[i].exp_note);
      check($sformatf("vec%0d_period", i), period, vecs[i].p);
      check($sformatf("vec%0d_active", i), active, 1);
      check($sformatf("vec%0d_sb", i), exp_q.size(), 0);
    end

    // Reset mid-tone at MI: clears immediately without a pulse, then relocks on the 3rd edge.
    exp_q.push_back(3'd3);
    tone(758, 3);
    check("mi_note", note, 3);
    beep_in = 1'b1;
    repeat (379) @(negedge sys_clk);
    beep_in = 1'b0;
    repeat (189) @(negedge sys_clk);
    pc = pulse_count;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("mrst_note", note, 0);
    check("mrst_period", period, 0);
    check("mrst_active", active, 0);
    check("mrst_nv", note_valid, 0);
    repeat (190) @(negedge sys_clk);
    check("mrst_no_pulse", pulse_count - pc, 0);
    exp_q.push_back(3'd3);
    tone(758, 3);
    check("relock_note", note, 3);
    check("relock_period", period, 758);
    check("relock_latency", last_pulse - last_rise, 4);
    check("relock_sb", exp_q.size(), 0);

    // Alternating DO/SI periods never build a run of two.
    pc = pulse_count;
    for (int i = 0; i < 3; i++) begin
      tone(954, 1);
      tone(506, 1);
    end
    check("alt_no_pulse", pulse_count - pc, 0);
    check("alt_note", note, 3);

    // LA then silence: one pulse to 0 exactly TIMEOUT cycles after the edge reloads the counter.
    exp_q.push_back(3'd6);
    tone(568, 3);
    check("la_note", note, 6);
    rise_ref = last_rise;
    exp_q.push_back(3'd0);
    pc = pulse_count;
    w = 0;
    while (pulse_count == pc && w < TO + 200) begin
      @(negedge sys_clk);
      w++;
    end
    check("to_pulse_seen", pulse_count - pc, 1);
    check("to_latency", last_pulse - rise_ref, TO + 3);
    check("to_note", note, 0);
    check("to_active", active, 0);
    pc = pulse_count;
    repeat (300) @(negedge sys_clk);
    check("to_no_more", pulse_count - pc, 0);
    check("final_sb", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
